// File: rtl/vend_dispense_arbiter.sv
// vend_dispense_arbiter
// Shares one product-dispense motor among N selection buttons. A round-robin
// pointer picks one pending selection. Its price is checked against the coin
// FSM credit, the motor runs for MOTOR_CYC cycles, and then deduct/ack pulse
// so the coin FSM subtracts the price.
// Build option: define JAM_DETECT_EN to watch the product-drop sensor while
// the motor runs. A drop ends the motor phase early. No drop before the motor
// time runs out is reported as a jam.
module vend_dispense_arbiter #(
    parameter int N         = 4,
    parameter int CRED_W    = 8,
    parameter int MOTOR_CYC = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req,
    input  logic [N*CRED_W-1:0]   price_bus,
    input  logic [CRED_W-1:0]     credit,
    input  logic                  drop_det,
    output logic [N-1:0]          gnt,
    output logic                  motor_on,
    output logic                  deduct_vld,
    output logic [CRED_W-1:0]     deduct_amt,
    output logic                  vend_ack,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  busy
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (MOTOR_CYC > 1) ? $clog2(MOTOR_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MOTOR_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MOTOR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CRED_W-1:0]  price_q, price_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic               motor_on_q, motor_on_d;
    logic               deduct_vld_q, deduct_vld_d;
    logic [CRED_W-1:0]  deduct_amt_q, deduct_amt_d;
    logic               vend_ack_q, vend_ack_d;
    logic               err_q, err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [CRED_W-1:0]  price_arr [N];

`ifndef JAM_DETECT_EN
    logic unused_drop_det;
    assign unused_drop_det = drop_det;
`endif

    for (genvar i = 0; i < N; i++) begin : g_price
        assign price_arr[i] = price_bus[i*CRED_W +: CRED_W];
    end

    // Slot reached by stepping 'step' positions past 'base', wrapping at N.
    function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= N) sum = sum - N;
        return IDX_W'(sum);
    endfunction

    // Round-robin pick: scan from farthest to nearest so the slot just after rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[rr_slot(rr_ptr_q, k)]) begin
                pick_found = 1'b1;
                pick_idx   = rr_slot(rr_ptr_q, k);
            end
        end
    end

    // Next-state and next-output logic for the grant / check / motor / done sequence.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        idx_d        = idx_q;
        price_d      = price_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        motor_on_d   = motor_on_q;
        deduct_vld_d = 1'b0;
        deduct_amt_d = '0;
        vend_ack_d   = 1'b0;
        err_d        = 1'b0;
        err_code_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    idx_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = CHECK;
                end
            end
            CHECK: begin
                price_d = price_arr[idx_q];
                if (credit >= price_arr[idx_q]) begin
                    motor_on_d = 1'b1;
                    cnt_d      = CNT_LOAD;
                    state_d    = MOTOR;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                    gnt_d      = '0;
                    rr_ptr_d   = idx_q;
                    state_d    = IDLE;
                end
            end
            MOTOR: begin
`ifdef JAM_DETECT_EN
                if (drop_det) begin
                    motor_on_d   = 1'b0;
                    vend_ack_d   = 1'b1;
                    deduct_vld_d = 1'b1;
                    deduct_amt_d = price_q;
                    state_d      = DONE;
                end else if (cnt_q == '0) begin
                    motor_on_d = 1'b0;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                    gnt_d      = '0;
                    rr_ptr_d   = idx_q;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`else
                if (cnt_q == '0) begin
                    motor_on_d   = 1'b0;
                    vend_ack_d   = 1'b1;
                    deduct_vld_d = 1'b1;
                    deduct_amt_d = price_q;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
`endif
            end
            DONE: begin
                gnt_d    = '0;
                rr_ptr_d = idx_q;
                state_d  = IDLE;
            end
            default: begin
                gnt_d      = '0;
                motor_on_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset points rr_ptr at N-1 so slot 0 goes first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= IDX_W'(N - 1);
            idx_q        <= '0;
            price_q      <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            motor_on_q   <= 1'b0;
            deduct_vld_q <= 1'b0;
            deduct_amt_q <= '0;
            vend_ack_q   <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            idx_q        <= idx_d;
            price_q      <= price_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            motor_on_q   <= motor_on_d;
            deduct_vld_q <= deduct_vld_d;
            deduct_amt_q <= deduct_amt_d;
            vend_ack_q   <= vend_ack_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign motor_on   = motor_on_q;
    assign deduct_vld = deduct_vld_q;
    assign deduct_amt = deduct_amt_q;
    assign vend_ack   = vend_ack_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
// tb_vend_dispense_arbiter
// Directed bench for vend_dispense_arbiter with N=4, CRED_W=8, MOTOR_CYC=8.
// Inputs change and outputs are sampled on the falling clock edge.
// "Cycle c" below means the value seen c rising edges after the IDLE cycle
// that sampled the request.
module tb_vend_dispense_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] price_bus;
    logic [7:0]  credit;
    logic        drop_det;
    logic [3:0]  gnt;
    logic        motor_on;
    logic        deduct_vld;
    logic [7:0]  deduct_amt;
    logic        vend_ack;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    vend_dispense_arbiter #(
        .N         (4),
        .CRED_W    (8),
        .MOTOR_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .price_bus  (price_bus),
        .credit     (credit),
        .drop_det   (drop_det),
        .gnt        (gnt),
        .motor_on   (motor_on),
        .deduct_vld (deduct_vld),
        .deduct_amt (deduct_amt),
        .vend_ack   (vend_ack),
        .err        (err),
        .err_code   (err_code),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkVector(input string tag, input logic [3:0] e_gnt, input logic e_on,
                               input logic e_busy, input logic e_ack, input logic e_dv,
                               input logic [7:0] e_amt, input logic e_err, input logic [1:0] e_code);
        checkOutput({tag, "_gnt"},      32'(gnt),        32'(e_gnt));
        checkOutput({tag, "_motor"},    32'(motor_on),   32'(e_on));
        checkOutput({tag, "_busy"},     32'(busy),       32'(e_busy));
        checkOutput({tag, "_ack"},      32'(vend_ack),   32'(e_ack));
        checkOutput({tag, "_dvld"},     32'(deduct_vld), 32'(e_dv));
        checkOutput({tag, "_damt"},     32'(deduct_amt), 32'(e_amt));
        checkOutput({tag, "_err"},      32'(err),        32'(e_err));
        checkOutput({tag, "_err_code"}, 32'(err_code),   32'(e_code));
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [7:0] cr, input logic [31:0] prices);
        req       = r;
        credit    = cr;
        price_bus = prices;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete successful vend: cycles 1..11 after the sampling IDLE cycle.
    task automatic serviceCheck(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_amt,
                                input bit drop_req, input bit disturb, input int drop_cycle);
        for (int c = 1; c <= 11; c++) begin
            stepCycle();
            checkVector($sformatf("%s_c%0d", tag, c),
                        (c <= 10) ? exp_gnt : 4'b0000,
                        (c >= 2 && c <= 9),
                        (c <= 10),
                        (c == 10),
                        (c == 10),
                        (c == 10) ? exp_amt : 8'd0,
                        1'b0, 2'b00);
            if (c == 1 && drop_req) req = 4'b0000;
            if (c == 3 && disturb) begin
                credit    = 8'd0;
                price_bus = '1;
            end
            drop_det = (c == drop_cycle);
        end
        drop_det = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        price_bus = '0;
        credit    = 8'd0;
        drop_det  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkVector("reset", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);
        rst = 1'b0;
        stepCycle();
        checkVector("idle", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);

        $display("[TB] round-robin with all requests held");
        applyStimulus(4'b1111, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10});
        serviceCheck("rr0", 4'b0001, 8'd10, 0, 0, 9);
        serviceCheck("rr1", 4'b0010, 8'd20, 0, 0, 9);
        serviceCheck("rr2", 4'b0100, 8'd30, 0, 0, 9);
        serviceCheck("rr3", 4'b1000, 8'd40, 0, 0, 9);
        serviceCheck("rr4", 4'b0001, 8'd10, 1, 0, 9);
        stepCycle();
        checkVector("rr_quiet", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);

        $display("[TB] insufficient credit");
        applyStimulus(4'b0100, 8'd10, {8'd40, 8'd15, 8'd20, 8'd10});
        stepCycle();
        checkVector("poor_c1", 4'b0100, 0, 1, 0, 0, 8'd0, 0, 2'b00);
        req = 4'b0000;
        stepCycle();
        checkVector("poor_c2", 4'b0000, 0, 0, 0, 0, 8'd0, 1, 2'b01);
        stepCycle();
        checkVector("poor_c3", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);

        $display("[TB] zero price with zero credit");
        applyStimulus(4'b1000, 8'd0, {8'd0, 8'd30, 8'd15, 8'd10});
        serviceCheck("free", 4'b1000, 8'd0, 1, 0, 9);

        $display("[TB] credit equal to price, inputs disturbed mid-vend");
        applyStimulus(4'b0010, 8'd15, {8'd40, 8'd30, 8'd15, 8'd10});
        serviceCheck("equal", 4'b0010, 8'd15, 1, 1, 9);

        $display("[TB] reset during motor run");
        applyStimulus(4'b0001, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10});
        stepCycle();
        checkVector("mid_c1", 4'b0001, 0, 1, 0, 0, 8'd0, 0, 2'b00);
        req = 4'b0000;
        for (int c = 2; c <= 4; c++) begin
            stepCycle();
            checkVector($sformatf("mid_c%0d", c), 4'b0001, 1, 1, 0, 0, 8'd0, 0, 2'b00);
        end
        rst = 1'b1;
        #1;
        checkVector("mid_async", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);
        stepCycle();
        checkVector("mid_held", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);
        rst = 1'b0;
        stepCycle();
        checkVector("mid_released", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);
        applyStimulus(4'b1001, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10});
        serviceCheck("post_rst_a", 4'b0001, 8'd10, 0, 0, 9);
        serviceCheck("post_rst_b", 4'b1000, 8'd40, 1, 0, 9);

`ifdef JAM_DETECT_EN
        $display("[TB] product drop in third motor cycle");
        applyStimulus(4'b0001, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10});
        stepCycle();
        checkVector("drop_c1", 4'b0001, 0, 1, 0, 0, 8'd0, 0, 2'b00);
        req = 4'b0000;
        for (int c = 2; c <= 4; c++) begin
            stepCycle();
            checkVector($sformatf("drop_c%0d", c), 4'b0001, 1, 1, 0, 0, 8'd0, 0, 2'b00);
        end
        drop_det = 1'b1;
        stepCycle();
        drop_det = 1'b0;
        checkVector("drop_c5", 4'b0001, 0, 1, 1, 1, 8'd10, 0, 2'b00);
        stepCycle();
        checkVector("drop_c6", 4'b0000, 0, 0, 0, 0, 8'd0, 0, 2'b00);

        $display("[TB] jam: no product drop");
        applyStimulus(4'b0010, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10});
        for (int c = 1; c <= 11; c++) begin
            stepCycle();
            checkVector($sformatf("jam_c%0d", c),
                        (c <= 9) ? 4'b0010 : 4'b0000,
                        (c >= 2 && c <= 9),
                        (c <= 9),
                        1'b0, 1'b0, 8'd0,
                        (c == 10),
                        (c == 10) ? 2'b10 : 2'b00);
            if (c == 1) req = 4'b0000;
        end
`else
        $display("[TB] drop sensor ignored");
        applyStimulus(4'b0100, 8'd255, {8'd40, 8'd30, 8'd20, 8'd10});
        serviceCheck("drop_ignored", 4'b0100, 8'd30, 1, 0, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
